// File: rtl/cct_request_arbiter.sv
// Round-robin arbiter sharing one CCT-to-XYZ converter between two requesters; grant->start 1 cycle,
// result edge->rsp 1 cycle, timeout abandons a silent conversion. No queuing: requesters hold req_valid until req_ready.
module cct_request_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  req_valid,
  input  logic [15:0] req0_cct,
  input  logic [15:0] req1_cct,
  output logic [1:0]  req_ready,
  output logic [15:0] conv_cct,
  output logic        conv_cct_valid,
  input  logic [95:0] conv_xyz,
  input  logic        conv_xyz_valid,
  output logic [95:0] rsp_xyz,
  output logic [1:0]  rsp_valid,
  output logic        rsp_timeout,
  output logic        rsp_id,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  localparam logic [15:0] TIMER_LAST = 16'(TIMEOUT_CYCLES - 1);

  state_t      state_q, state_d;
  logic [15:0] timer_q, timer_d;
  logic [15:0] cct_q, cct_d;
  logic [95:0] xyz_q, xyz_d;
  logic        id_q, id_d;
  logic        ptr_q, ptr_d;
  logic        valid_q;

  logic        result_evt;
  logic        grant_idx;
  logic [1:0]  ready_c;
  logic [1:0]  rsp_valid_c;
  logic        start_c;
  logic        timeout_c;

  // Only a fresh rising edge counts, so a level held over from the last result is not re-captured.
  assign result_evt = conv_xyz_valid & ~valid_q;
  assign grant_idx  = (req_valid == 2'b11) ? ~ptr_q : req_valid[1];

  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q;
    cct_d       = cct_q;
    xyz_d       = xyz_q;
    id_d        = id_q;
    ptr_d       = ptr_q;
    ready_c     = 2'b00;
    rsp_valid_c = 2'b00;
    start_c     = 1'b0;
    timeout_c   = 1'b0;
    case (state_q)
      IDLE: begin
        if (|req_valid) begin
          ready_c = grant_idx ? 2'b10 : 2'b01;
          cct_d   = grant_idx ? req1_cct : req0_cct;
          id_d    = grant_idx;
          ptr_d   = grant_idx;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        start_c = 1'b1;
        timer_d = 16'd0;
        state_d = WAIT;
      end
      WAIT: begin
        if (result_evt) begin
          xyz_d   = conv_xyz;
          state_d = DONE;
        end else if (timer_q == TIMER_LAST) begin
          timeout_c = 1'b1;
          state_d   = IDLE;
        end else begin
          timer_d = timer_q + 16'd1;
        end
      end
      DONE: begin
        rsp_valid_c = id_q ? 2'b10 : 2'b01;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      timer_q <= 16'd0;
      cct_q   <= 16'd0;
      xyz_q   <= 96'd0;
      id_q    <= 1'b0;
      ptr_q   <= 1'b1;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      cct_q   <= cct_d;
      xyz_q   <= xyz_d;
      id_q    <= id_d;
      ptr_q   <= ptr_d;
      valid_q <= conv_xyz_valid;
    end
  end

  // Strobes are masked by rst so they read idle for the whole time reset is held.
  assign req_ready      = rst ? 2'b00 : ready_c;
  assign conv_cct_valid = ~rst & start_c;
  assign rsp_valid      = rst ? 2'b00 : rsp_valid_c;
  assign rsp_timeout    = ~rst & timeout_c;
  assign busy           = ~rst & (state_q != IDLE);
  assign conv_cct       = cct_q;
  assign rsp_xyz        = xyz_q;
  assign rsp_id         = id_q;

endmodule
